// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two valid/ready requesters.
// Operands are registered before the ALU and results after it, so no request-to-response path exists.
module alu_arbiter #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned PRIO_INIT = 0,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_ctrl,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_res,
    output logic [3:0]       rsp0_flags,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_ctrl,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_res,
    output logic [3:0]       rsp1_flags,
    output logic             busy,
    output logic [CNT_W-1:0] done0_cnt,
    output logic [CNT_W-1:0] done1_cnt
);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_EXEC = 2'b01;
    localparam logic [1:0] S_RESP = 2'b10;
    localparam logic       PRIO_BIT = 1'(PRIO_INIT);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             last_ptr;
    logic             owner;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [1:0]       op_ctrl;

    logic             grant_c;
    logic             accept_c;
    logic             done0_c;
    logic             done1_c;

    logic [WIDTH:0]   alu_sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             alu_ovf;
    logic [3:0]       alu_flags;

    // Grant: a lone requester wins; on contention the port that did not finish last wins.
    always_comb begin
        grant_c = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_c = ~last_ptr;
        end else if (req1_valid) begin
            grant_c = 1'b1;
        end
    end

    assign req0_ready = (state == S_IDLE) && req0_valid && !grant_c;
    assign req1_ready = (state == S_IDLE) && req1_valid && grant_c;
    assign accept_c   = req0_ready || req1_ready;
    assign done0_c    = rsp0_valid && rsp0_ready;
    assign done1_c    = rsp1_valid && rsp1_ready;

    // State register; busy is registered alongside so it tracks state exactly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != S_IDLE);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept_c) state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_RESP;
            S_RESP:  if (done0_c || done1_c) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Shared ALU: ctrl 00 add, 01 sub, 10 and, 11 or; flags = {n, z, c, v}, c on sub means no borrow.
    always_comb begin
        alu_sum   = '0;
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_flags = '0;
        case (op_ctrl)
            2'b00: begin
                alu_sum   = {1'b0, op_a} + {1'b0, op_b};
                alu_res   = alu_sum[WIDTH-1:0];
                alu_carry = alu_sum[WIDTH];
                alu_ovf   = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
            end
            2'b01: begin
                alu_sum   = {1'b0, op_a} + {1'b0, ~op_b} + {{WIDTH{1'b0}}, 1'b1};
                alu_res   = alu_sum[WIDTH-1:0];
                alu_carry = alu_sum[WIDTH];
                alu_ovf   = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
            end
            2'b10:   alu_res = op_a & op_b;
            default: alu_res = op_a | op_b;
        endcase
        alu_flags = {alu_res[WIDTH-1], (alu_res == '0), alu_carry, alu_ovf};
    end

    // Operand capture, result capture, response handshake and completion bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_ptr   <= ~PRIO_BIT;
            owner      <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            op_ctrl    <= '0;
            rsp0_valid <= 1'b0;
            rsp0_res   <= '0;
            rsp0_flags <= '0;
            rsp1_valid <= 1'b0;
            rsp1_res   <= '0;
            rsp1_flags <= '0;
            done0_cnt  <= '0;
            done1_cnt  <= '0;
        end else begin
            if (accept_c) begin
                owner   <= grant_c;
                op_a    <= grant_c ? req1_a    : req0_a;
                op_b    <= grant_c ? req1_b    : req0_b;
                op_ctrl <= grant_c ? req1_ctrl : req0_ctrl;
            end
            if (state == S_EXEC) begin
                if (owner) begin
                    rsp1_valid <= 1'b1;
                    rsp1_res   <= alu_res;
                    rsp1_flags <= alu_flags;
                end else begin
                    rsp0_valid <= 1'b1;
                    rsp0_res   <= alu_res;
                    rsp0_flags <= alu_flags;
                end
            end
            if (done0_c) begin
                rsp0_valid <= 1'b0;
                done0_cnt  <= done0_cnt + CNT_W'(1);
                last_ptr   <= 1'b0;
            end
            if (done1_c) begin
                rsp1_valid <= 1'b0;
                done1_cnt  <= done1_cnt + CNT_W'(1);
                last_ptr   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: table of single operations plus hand-written
// contention, back-pressure, stability, reset and counter-wrap sequences.
module tb_alu_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready;
    logic [31:0] req0_a, req0_b, rsp0_res;
    logic [1:0]  req0_ctrl;
    logic [3:0]  rsp0_flags;
    logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready;
    logic [31:0] req1_a, req1_b, rsp1_res;
    logic [1:0]  req1_ctrl;
    logic [3:0]  rsp1_flags;
    logic        busy;
    logic [15:0] done0_cnt, done1_cnt;

    logic        reset_b;
    logic        req0_valid_b, req0_ready_b, rsp0_valid_b, rsp0_ready_b;
    logic [31:0] req0_a_b, req0_b_b, rsp0_res_b;
    logic [1:0]  req0_ctrl_b;
    logic [3:0]  rsp0_flags_b;
    logic        req1_valid_b, req1_ready_b, rsp1_valid_b, rsp1_ready_b;
    logic [31:0] req1_a_b, req1_b_b, rsp1_res_b;
    logic [1:0]  req1_ctrl_b;
    logic [3:0]  rsp1_flags_b;
    logic        busy_b;
    logic [1:0]  done0_cnt_b, done1_cnt_b;

    int n_vec = 0;
    int n_err = 0;

    alu_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ctrl(req0_ctrl), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_res(rsp0_res), .rsp0_flags(rsp0_flags),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ctrl(req1_ctrl), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_res(rsp1_res), .rsp1_flags(rsp1_flags),
        .busy(busy), .done0_cnt(done0_cnt), .done1_cnt(done1_cnt)
    );

    alu_arbiter #(.WIDTH(32), .PRIO_INIT(1), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset_b),
        .req0_valid(req0_valid_b), .req0_ready(req0_ready_b), .req0_a(req0_a_b), .req0_b(req0_b_b),
        .req0_ctrl(req0_ctrl_b), .rsp0_valid(rsp0_valid_b), .rsp0_ready(rsp0_ready_b),
        .rsp0_res(rsp0_res_b), .rsp0_flags(rsp0_flags_b),
        .req1_valid(req1_valid_b), .req1_ready(req1_ready_b), .req1_a(req1_a_b), .req1_b(req1_b_b),
        .req1_ctrl(req1_ctrl_b), .rsp1_valid(rsp1_valid_b), .rsp1_ready(rsp1_ready_b),
        .rsp1_res(rsp1_res_b), .rsp1_flags(rsp1_flags_b),
        .busy(busy_b), .done0_cnt(done0_cnt_b), .done1_cnt(done1_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    typedef struct {
        bit          port;
        logic [1:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flags;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One operation on the default DUT, called at a falling edge; returns result and accept-to-valid edges.
    task automatic run_op(input bit p, input logic [31:0] a, input logic [31:0] b, input logic [1:0] c,
                          output logic [31:0] r, output logic [3:0] f, output int lat);
        int n;
        if (!p) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_ctrl = c;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_ctrl = c;
        end
        #1;
        n = 0;
        while (!(p ? req1_ready : req0_ready) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk("accept_timeout", 64'(n >= 20), 64'(0));
        @(posedge clk);
        @(negedge clk);
        if (!p) req0_valid = 1'b0; else req1_valid = 1'b0;
        lat = 1;
        while (!(p ? rsp1_valid : rsp0_valid) && lat < 20) begin
            @(negedge clk); lat++;
        end
        r = p ? rsp1_res : rsp0_res;
        f = p ? rsp1_flags : rsp0_flags;
        @(negedge clk);
    endtask

    initial begin
        vec_t        vecs [10];
        int          exp_wrap [5];
        int          order [8];
        int          ng, cyc, lat, n;
        logic [31:0] r;
        logic [3:0]  f;

        vecs[0] = '{1'b0, 2'b00, 32'd5,        32'd3,        32'd8,        4'b0000};
        vecs[1] = '{1'b1, 2'b01, 32'd10,       32'd4,        32'd6,        4'b0010};
        vecs[2] = '{1'b0, 2'b00, 32'hFFFFFFFF, 32'd1,        32'd0,        4'b0110};
        vecs[3] = '{1'b1, 2'b00, 32'h7FFFFFFF, 32'd1,        32'h80000000, 4'b1001};
        vecs[4] = '{1'b0, 2'b01, 32'd3,        32'd5,        32'hFFFFFFFE, 4'b1000};
        vecs[5] = '{1'b1, 2'b10, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 4'b0000};
        vecs[6] = '{1'b0, 2'b11, 32'hF0000000, 32'h0000000F, 32'hF000000F, 4'b1000};
        vecs[7] = '{1'b1, 2'b01, 32'h80000000, 32'd1,        32'h7FFFFFFF, 4'b0011};
        vecs[8] = '{1'b0, 2'b10, 32'h12345678, 32'd0,        32'd0,        4'b0100};
        vecs[9] = '{1'b1, 2'b01, 32'd5,        32'd5,        32'd0,        4'b0110};
        exp_wrap[0] = 1; exp_wrap[1] = 2; exp_wrap[2] = 3; exp_wrap[3] = 0; exp_wrap[4] = 1;

        reset = 1'b0; reset_b = 1'b0;
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_ctrl = 0; rsp0_ready = 1;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_ctrl = 0; rsp1_ready = 1;
        req0_valid_b = 0; req0_a_b = 0; req0_b_b = 0; req0_ctrl_b = 0; rsp0_ready_b = 1;
        req1_valid_b = 0; req1_a_b = 0; req1_b_b = 0; req1_ctrl_b = 0; rsp1_ready_b = 1;
        repeat (2) @(negedge clk);
        chk("reset_state", {busy, rsp0_valid, rsp1_valid, done0_cnt, done1_cnt, rsp0_flags, rsp1_flags},
            64'(0));
        chk("reset_res", {rsp0_res, rsp1_res}, 64'(0));
        reset = 1'b1; reset_b = 1'b1;

        // Table of single operations, alternating ports.
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].ctrl, r, f, lat);
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'(2));
            chk($sformatf("v%0d_res", i), 64'(r), 64'(vecs[i].res));
            chk($sformatf("v%0d_flags", i), 64'(f), 64'(vecs[i].flags));
        end
        chk("table_counts", {busy, done0_cnt, done1_cnt}, {31'd0, 1'b0, 16'd5, 16'd5});

        // Contention after reset: grants alternate starting from port 0.
        reset = 1'b0; @(negedge clk); reset = 1'b1;
        req0_a = 32'd5;  req0_b = 32'd3; req0_ctrl = 2'b00;
        req1_a = 32'd10; req1_b = 32'd4; req1_ctrl = 2'b01;
        req0_valid = 1'b1; req1_valid = 1'b1;
        ng = 0; cyc = 0;
        while (ng < 8 && cyc < 100) begin
            #1;
            if (req0_ready) begin order[ng] = 0; ng++; end
            if (req1_ready && ng < 8) begin order[ng] = 1; ng++; end
            if (rsp0_valid) chk("cont_res0", 64'(rsp0_res), 64'(8));
            if (rsp1_valid) chk("cont_res1", 64'(rsp1_res), 64'(6));
            @(negedge clk); cyc++;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("cont_grants", 64'(ng), 64'(8));
        for (int k = 0; k < 8; k++) chk($sformatf("cont_order%0d", k), 64'(order[k]), 64'(k % 2));
        repeat (3) @(negedge clk);
        chk("cont_counts", {done0_cnt, done1_cnt}, {32'd0, 16'd4, 16'd4});

        // Back-pressure on port 1 while port 0 waits.
        rsp1_ready = 1'b0;
        run_op(1'b1, 32'd20, 32'd7, 2'b01, r, f, lat);
        chk("bp_res", {r, f}, {28'd0, 32'd13, 4'b0010});
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_ctrl = 2'b00;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk($sformatf("bp_stall%0d", k), {req0_ready, busy, rsp1_valid, rsp1_res, rsp1_flags},
                {25'd0, 1'b0, 1'b1, 1'b1, 32'd13, 4'b0010});
            @(negedge clk);
        end
        rsp1_ready = 1'b1;
        @(negedge clk); #1;
        chk("bp_release_ready", {req0_ready, rsp1_valid}, 64'(2'b10));
        run_op(1'b0, 32'd1, 32'd2, 2'b00, r, f, lat);
        chk("bp_port0_res", {r, f}, {28'd0, 32'd3, 4'b0000});
        chk("bp_nonowner_hold", {rsp1_valid, rsp1_res}, {31'd0, 1'b0, 32'd13});

        // Operand changes while waiting only matter on the accept edge.
        req1_valid = 1'b1; req1_a = 32'd2; req1_b = 32'd2; req1_ctrl = 2'b00;
        #1; chk("stab_grant1", 64'(req1_ready), 64'(1));
        @(posedge clk); @(negedge clk);
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd100; req0_b = 32'd1; req0_ctrl = 2'b00;
        @(negedge clk);
        req0_a = 32'd200;
        chk("stab_rsp1", {rsp1_valid, rsp1_res}, {31'd0, 1'b1, 32'd4});
        @(negedge clk);
        req0_a = 32'd300;
        #1; chk("stab_ready0", 64'(req0_ready), 64'(1));
        @(posedge clk); @(negedge clk);
        req0_a = 32'd999; req0_valid = 1'b0;
        n = 0;
        while (!rsp0_valid && n < 10) begin @(negedge clk); n++; end
        chk("stab_res", {rsp0_valid, rsp0_res}, {31'd0, 1'b1, 32'd301});
        @(negedge clk);

        // Reset during EXEC discards the operation.
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_ctrl = 2'b00;
        #1; @(posedge clk); @(negedge clk);
        req0_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_mid", {busy, rsp0_valid, rsp1_valid, done0_cnt, done1_cnt}, 64'(0));
        @(negedge clk); reset = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_discard", {busy, rsp0_valid, rsp0_res}, 64'(0));

        // Second DUT: 2-bit counter wrap on port 0.
        for (int i = 0; i < 5; i++) begin
            req0_valid_b = 1'b1; req0_a_b = 32'(i + 1); req0_b_b = 32'd0; req0_ctrl_b = 2'b00;
            #1; chk($sformatf("wrap_ready%0d", i), 64'(req0_ready_b), 64'(1));
            @(posedge clk); @(negedge clk);
            req0_valid_b = 1'b0;
            n = 0;
            while (!rsp0_valid_b && n < 10) begin @(negedge clk); n++; end
            chk($sformatf("wrap_res%0d", i), {rsp0_valid_b, rsp0_res_b}, {31'd0, 1'b1, 32'(i + 1)});
            @(negedge clk);
            chk($sformatf("wrap_cnt%0d", i), 64'(done0_cnt_b), 64'(exp_wrap[i]));
        end

        // Second DUT: reset mid-op, then PRIO_INIT=1 grants port 1 first.
        req0_valid_b = 1'b1; req0_a_b = 32'd7;
        #1; @(posedge clk); @(negedge clk);
        reset_b = 1'b0;
        req1_valid_b = 1'b1;
        #1;
        chk("b_rst_mid", {busy_b, rsp0_valid_b, rsp1_valid_b, done0_cnt_b, done1_cnt_b,
                          rsp0_flags_b, rsp1_flags_b}, 64'(0));
        chk("b_rst_res", {rsp0_res_b, rsp1_res_b}, 64'(0));
        @(negedge clk); reset_b = 1'b1;
        #1;
        chk("b_prio_grant", {req0_ready_b, req1_ready_b}, 64'(2'b01));
        @(negedge clk);
        req0_valid_b = 1'b0; req1_valid_b = 1'b0;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
